// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder (state encoding, rw defaults, parity).
// Parity storage is compiled in only when MEMRESP_PARITY_EN is defined.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITS = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic REN_DEF  = 1'b0;
  localparam logic WEN_DEF  = 1'b1;
  localparam int   CNT_W    = 4;
  localparam int   PAR_MAXW = 64;

  // Even parity: the returned bit makes the total count of ones (data + bit) even.
  function automatic logic even_par(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: writes commit on the rising edge, reads are combinational on the same address.
// Width includes the parity bit when the top is built with MEMRESP_PARITY_EN.
module mem_array
  import mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  // Combinational read lets the responder register data and parity status on the access edge.
  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: captures a CPU request, waits WAIT cycles, performs the access, pulses memRdy.
// Define MEMRESP_PARITY_EN to store an even-parity bit per word and report read mismatches on parErr.
module mem_responder
  import mem_pkg::*;
#(
  parameter int   BUSW  = 32,
  parameter int   MINDW = 8,
  parameter int   WAIT  = 2,
  parameter logic REN   = REN_DEF,
  parameter logic WEN   = WEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mutexLow,
  input  logic             mrwen,
  input  logic [MINDW-1:0] MemInd,
  input  logic [BUSW-1:0]  MemDbusIn,
  output logic [BUSW-1:0]  MemDbusOut,
  output logic             memRdy,
  output logic             busy
`ifdef MEMRESP_PARITY_EN
  ,
  output logic             parErr
`endif
);

`ifdef MEMRESP_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int DW = BUSW + PW;

  if (REN == WEN) begin : g_bad_rw
    $error("mem_responder: REN and WEN must differ");
  end
  if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
    $error("mem_responder: WAIT must be within 0..15");
  end
`ifdef MEMRESP_PARITY_EN
  if (BUSW > PAR_MAXW) begin : g_bad_busw
    $error("mem_responder: BUSW too wide for the parity helper");
  end
`endif

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rw;
  logic [MINDW-1:0]   r_addr;
  logic [BUSW-1:0]    r_wdata;
  logic               w_access;
  logic               w_we;
  logic [DW-1:0]      w_wr;
  logic [DW-1:0]      w_rd;

  assign w_access = (r_state == WAITS) && (r_cnt == '0);
  assign w_we     = w_access && (r_rw == WEN);

`ifdef MEMRESP_PARITY_EN
  logic w_perr;
  assign w_wr   = {even_par(PAR_MAXW'(r_wdata)), r_wdata};
  assign w_perr = (even_par(PAR_MAXW'(w_rd[BUSW-1:0])) != w_rd[BUSW]);
`else
  assign w_wr   = r_wdata;
`endif

  mem_array #(
    .DW (DW),
    .AW (MINDW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (w_wr),
    .o_rdata (w_rd)
  );

  // Request holding registers are pure data and carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && !mutexLow) begin
      r_rw    <= mrwen;
      r_addr  <= MemInd;
      r_wdata <= MemDbusIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      MemDbusOut <= '0;
      memRdy     <= 1'b0;
      busy       <= 1'b0;
`ifdef MEMRESP_PARITY_EN
      parErr     <= 1'b0;
`endif
    end else begin
      memRdy <= 1'b0;
`ifdef MEMRESP_PARITY_EN
      parErr <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (!mutexLow) begin
            r_cnt   <= CNT_W'(WAIT);
            r_state <= WAITS;
            busy    <= 1'b1;
          end
        end
        WAITS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            memRdy  <= 1'b1;
            r_state <= DONE;
            if (r_rw != WEN) begin
              MemDbusOut <= w_rd[BUSW-1:0];
`ifdef MEMRESP_PARITY_EN
              parErr     <= w_perr;
`endif
            end
          end
        end
        DONE: begin
          // A request held low stays parked here; the bus must be released for one edge.
          if (mutexLow) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: WAIT=2 instance for most scenarios, WAIT=0 instance for held requests.
// Parity scenario is compiled when MEMRESP_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mutexLow = 1'b1;
  logic        mrwen = 1'b0;
  logic [7:0]  MemInd = '0;
  logic [31:0] MemDbusIn = '0;
  logic [31:0] MemDbusOut;
  logic        memRdy;
  logic        busy;

  logic        c0_mutexLow = 1'b1;
  logic        c0_mrwen = 1'b0;
  logic [7:0]  c0_MemInd = '0;
  logic [31:0] c0_MemDbusIn = '0;
  logic [31:0] c0_MemDbusOut;
  logic        c0_memRdy;
  logic        c0_busy;
`ifdef MEMRESP_PARITY_EN
  logic        parErr;
  logic        c0_parErr;
`endif

  mem_responder #(.BUSW(32), .MINDW(8), .WAIT(WAIT_A)) dut (
    .clk(clk), .rst_n(rst_n), .mutexLow(mutexLow), .mrwen(mrwen), .MemInd(MemInd),
    .MemDbusIn(MemDbusIn), .MemDbusOut(MemDbusOut), .memRdy(memRdy), .busy(busy)
`ifdef MEMRESP_PARITY_EN
    , .parErr(parErr)
`endif
  );

  mem_responder #(.BUSW(32), .MINDW(8), .WAIT(WAIT_B)) dut0 (
    .clk(clk), .rst_n(rst_n), .mutexLow(c0_mutexLow), .mrwen(c0_mrwen), .MemInd(c0_MemInd),
    .MemDbusIn(c0_MemDbusIn), .MemDbusOut(c0_MemDbusOut), .memRdy(c0_memRdy), .busy(c0_busy)
`ifdef MEMRESP_PARITY_EN
    , .parErr(c0_parErr)
`endif
  );

  int n_checks = 0;
  int n_errs = 0;

  // Reference model: word contents, which words are defined, and the last read value on the bus.
  logic [31:0] mdl_mem [256];
  bit          mdl_vld [256];
  logic [31:0] mdl_out;
  logic [7:0]  wr_addrs [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // One complete transaction on the WAIT=2 instance; request held low until memRdy, then released.
  task automatic do_req(input logic rw, input logic [7:0] a, input logic [31:0] d,
                        input bit scramble, input bit exp_perr);
    int n;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    mutexLow = 1'b0; mrwen = rw; MemInd = a; MemDbusIn = d;
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (memRdy) seen = 1;
      else begin
        if (!busy) busy_ok = 0;
        if (scramble) begin
          MemInd = 8'($urandom); MemDbusIn = $urandom; mrwen = ~rw;
        end
      end
    end
    if (!seen) begin
      chk("rdy_timeout", 32'(0), 32'(1));
      mutexLow = 1'b1;
      return;
    end
    chk("latency", 32'(n), 32'(WAIT_A + 2));
    chk("busy_during_wait", 32'(busy_ok), 32'(1));
    chk("busy_at_rdy", 32'(busy), 32'(1));
    if (rw == 1'b1) begin
      mdl_mem[a] = d; mdl_vld[a] = 1; wr_addrs.push_back(a);
      chk("dout_held_on_write", MemDbusOut, mdl_out);
    end else begin
      if (mdl_vld[a]) mdl_out = mdl_mem[a];
      chk("read_data", MemDbusOut, mdl_out);
    end
`ifdef MEMRESP_PARITY_EN
    chk("perr_at_rdy", 32'(parErr), 32'(exp_perr));
`else
    if (exp_perr) chk("perr_unsupported", 32'(0), 32'(1));
`endif
    mutexLow = 1'b1;
    @(negedge clk);
    chk("rdy_one_cycle", 32'(memRdy), 32'(0));
    chk("busy_release", 32'(busy), 32'(0));
`ifdef MEMRESP_PARITY_EN
    chk("perr_clear", 32'(parErr), 32'(0));
`endif
  endtask

  // Request on the WAIT=0 instance held low for 'hold' cycles; reports memRdy pulses seen.
  task automatic req0(input logic rw, input logic [7:0] a, input logic [31:0] d, input int hold,
                      output int pulses, output int first, output logic [31:0] data,
                      output logic busy_end);
    @(negedge clk);
    c0_mutexLow = 1'b0; c0_mrwen = rw; c0_MemInd = a; c0_MemDbusIn = d;
    pulses = 0; first = 0; data = '0; busy_end = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (c0_memRdy) begin
        pulses++;
        if (first == 0) begin first = i; data = c0_MemDbusOut; end
      end
      if (i == hold) busy_end = c0_busy;
    end
    c0_mutexLow = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int pulses, first;
    logic [31:0] data;
    logic busy_end;
    logic rw;
    logic [7:0] a;

    for (int i = 0; i < 256; i++) mdl_vld[i] = 0;

    repeat (2) @(negedge clk);
    chk("rst_dout", MemDbusOut, 32'h0);
    chk("rst_rdy", 32'(memRdy), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_dout0", c0_MemDbusOut, 32'h0);
    chk("rst_busy0", 32'(c0_busy), 32'(0));
`ifdef MEMRESP_PARITY_EN
    chk("rst_perr", 32'(parErr), 32'(0));
`endif
    rst_n = 1'b1;
    mdl_out = 32'h0;

    do_req(1'b1, 8'h03, 32'hA5A5_0001, 0, 0);
    do_req(1'b0, 8'h03, 32'h0, 0, 0);

    do_req(1'b1, 8'hFF, 32'hFFFF_FFFF, 0, 0);
    do_req(1'b1, 8'h00, 32'h0000_0000, 0, 0);
    do_req(1'b0, 8'hFF, 32'h0, 0, 0);
    do_req(1'b0, 8'h00, 32'h0, 0, 0);

    do_req(1'b1, 8'h40, 32'h1357_9BDF, 1, 0);
    do_req(1'b0, 8'h40, 32'h0, 1, 0);
    do_req(1'b0, 8'h03, 32'h0, 0, 0);

    // Reset while a write to 0x10 is still waiting: the old contents must survive.
    do_req(1'b1, 8'h10, 32'h1122_3344, 0, 0);
    do_req(1'b0, 8'h10, 32'h0, 0, 0);
    @(negedge clk);
    mutexLow = 1'b0; mrwen = 1'b1; MemInd = 8'h10; MemDbusIn = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b0; mutexLow = 1'b1;
    #1;
    chk("midrst_dout", MemDbusOut, 32'h0);
    chk("midrst_rdy", 32'(memRdy), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    chk("midrst_dout_hold", MemDbusOut, 32'h0);
    chk("midrst_busy_hold", 32'(busy), 32'(0));
    rst_n = 1'b1;
    mdl_out = 32'h0;
    do_req(1'b0, 8'h10, 32'h0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom_range(0, 1));
      if (rw == 1'b0 && wr_addrs.size() > 0) a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
      else begin rw = 1'b1; a = 8'($urandom); end
      do_req(rw, a, $urandom, 1'($urandom_range(0, 1)), 0);
    end

`ifdef MEMRESP_PARITY_EN
    do_req(1'b1, 8'h07, 32'h0F0F_1234, 0, 0);
    @(negedge clk);
    dut.u_array.r_mem[7][0] = ~dut.u_array.r_mem[7][0];
    mdl_mem[7] = mdl_mem[7] ^ 32'h1;
    do_req(1'b0, 8'h07, 32'h0, 0, 1);
    do_req(1'b0, 8'h03, 32'h0, 0, 0);
`endif

    req0(1'b1, 8'h20, 32'hCAFE_F00D, 2, pulses, first, data, busy_end);
    chk("w0_wr_pulses", 32'(pulses), 32'(1));
    chk("w0_wr_latency", 32'(first), 32'(WAIT_B + 2));
    req0(1'b0, 8'h20, 32'h0, 5, pulses, first, data, busy_end);
    chk("w0_rd_pulses", 32'(pulses), 32'(1));
    chk("w0_rd_latency", 32'(first), 32'(WAIT_B + 2));
    chk("w0_rd_data", data, 32'hCAFE_F00D);
    chk("w0_busy_held", 32'(busy_end), 32'(1));
    chk("w0_busy_release", 32'(c0_busy), 32'(0));
    chk("w0_no_rdy_idle", 32'(c0_memRdy), 32'(0));
    @(negedge clk);
    chk("w0_still_idle", 32'(c0_busy), 32'(0));
    req0(1'b0, 8'h20, 32'h0, 3, pulses, first, data, busy_end);
    chk("w0_rd2_pulses", 32'(pulses), 32'(1));
    chk("w0_rd2_data", data, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
